// File: rtl/cacheline_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_port_arbiter
// Description : Shares one cacheline-adaptor (burst memory) port between the
//               icache miss path and the dcache miss/writeback path. One
//               256-bit line transaction is in flight at a time. The winner's
//               address (line aligned) and write data are latched, a single
//               mem_read or mem_write is sequenced, and a one-cycle resp plus
//               the returned line are handed back to the owning cache.
//
// Parameters  : DCACHE_FIRST  1 = dcache wins a simultaneous request,
//                             0 = icache wins.
//               STARVE_LIMIT  consecutive contended grants to the priority
//                             side before the other side is forced through
//                             (only meaningful with ARB_STARVE_GUARD_EN).
//
// Macro       : ARB_STARVE_GUARD_EN  enables the anti-starvation counter.
//               Undefined (default) gives strict fixed priority.
//
// Ports       : clk, rst          clock, synchronous active-high reset
//               icache_addr/read  icache line request (held until resp)
//               icache_rdata/resp line and completion pulse to icache
//               dcache_addr/read/write/wdata  dcache request (held until resp)
//               dcache_rdata/resp line and completion pulse to dcache
//               mem_addr/read/write/wdata     request to cacheline adaptor
//               mem_rdata/resp    line and completion from adaptor
//               arb_busy          high whenever the arbiter is not idle
//
// Revision    : 1.0  initial release
// ============================================================================
module cacheline_port_arbiter #(
    parameter int DCACHE_FIRST = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    // icache side
    input  logic [31:0]  icache_addr,
    input  logic         icache_read,
    output logic [255:0] icache_rdata,
    output logic         icache_resp,
    // dcache side
    input  logic [31:0]  dcache_addr,
    input  logic         dcache_read,
    input  logic         dcache_write,
    input  logic [255:0] dcache_wdata,
    output logic [255:0] dcache_rdata,
    output logic         dcache_resp,
    // adaptor side
    output logic [31:0]  mem_addr,
    output logic         mem_read,
    output logic         mem_write,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata,
    input  logic         mem_resp,
    // status
    output logic         arb_busy
);

    localparam logic [2:0]  S_IDLE   = 3'd0;
    localparam logic [2:0]  S_MEM_I  = 3'd1;
    localparam logic [2:0]  S_MEM_D  = 3'd2;
    localparam logic [2:0]  S_RESP_I = 3'd3;
    localparam logic [2:0]  S_RESP_D = 3'd4;

    localparam logic        c_dcache_first = (DCACHE_FIRST != 0);
    localparam logic [31:0] c_line_mask    = 32'hFFFF_FFE0;

    logic [2:0]   r_state;
    logic [31:0]  r_mem_addr;
    logic         r_mem_read;
    logic         r_mem_write;
    logic [255:0] r_mem_wdata;
    logic [255:0] r_icache_rdata;
    logic [255:0] r_dcache_rdata;
    logic         r_icache_resp;
    logic         r_dcache_resp;

    logic         w_i_req;
    logic         w_d_req;
    logic         w_contend;
    logic         w_grant_d;

    assign w_i_req   = icache_read;
    assign w_d_req   = dcache_read | dcache_write;
    assign w_contend = w_i_req & w_d_req;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [2:0] c_starve_limit = 3'(STARVE_LIMIT);

    logic [2:0] r_starve_cnt;
    logic       w_starved;

    assign w_starved = (r_starve_cnt >= c_starve_limit);

    // Under contention the priority side wins unless it has already taken
    // STARVE_LIMIT grants in a row, in which case the other side goes.
    assign w_grant_d = w_contend ? (c_dcache_first ^ w_starved) : w_d_req;

    // Counts back-to-back contended grants to the priority side. Any IDLE
    // cycle without contention, or a forced grant, restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 3'd0;
        end else if (r_state == S_IDLE) begin
            if (!w_contend || w_starved) begin
                r_starve_cnt <= 3'd0;
            end else if (r_starve_cnt != 3'd7) begin
                r_starve_cnt <= r_starve_cnt + 3'd1;
            end
        end
    end
`else
    assign w_grant_d = w_contend ? c_dcache_first : w_d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_mem_addr     <= 32'd0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_wdata    <= 256'd0;
            r_icache_rdata <= 256'd0;
            r_dcache_rdata <= 256'd0;
            r_icache_resp  <= 1'b0;
            r_dcache_resp  <= 1'b0;
        end else begin
            // Responses are single-cycle pulses.
            r_icache_resp <= 1'b0;
            r_dcache_resp <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_d_req && w_grant_d) begin
                        r_mem_addr  <= dcache_addr & c_line_mask;
                        // Read and write together is treated as a write.
                        r_mem_write <= dcache_write;
                        r_mem_read  <= ~dcache_write;
                        if (dcache_write) begin
                            r_mem_wdata <= dcache_wdata;
                        end
                        r_state <= S_MEM_D;
                    end else if (w_i_req) begin
                        r_mem_addr  <= icache_addr & c_line_mask;
                        r_mem_read  <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_state     <= S_MEM_I;
                    end
                end

                S_MEM_I: begin
                    if (mem_resp) begin
                        r_mem_read     <= 1'b0;
                        r_mem_write    <= 1'b0;
                        r_icache_rdata <= mem_rdata;
                        r_icache_resp  <= 1'b1;
                        r_state        <= S_RESP_I;
                    end
                end

                S_MEM_D: begin
                    if (mem_resp) begin
                        // A writeback returns no line; keep the last one.
                        if (r_mem_read) begin
                            r_dcache_rdata <= mem_rdata;
                        end
                        r_mem_read    <= 1'b0;
                        r_mem_write   <= 1'b0;
                        r_dcache_resp <= 1'b1;
                        r_state       <= S_RESP_D;
                    end
                end

                S_RESP_I, S_RESP_D: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign icache_rdata = r_icache_rdata;
    assign icache_resp  = r_icache_resp;
    assign dcache_rdata = r_dcache_rdata;
    assign dcache_resp  = r_dcache_resp;
    assign mem_addr     = r_mem_addr;
    assign mem_read     = r_mem_read;
    assign mem_write    = r_mem_write;
    assign mem_wdata    = r_mem_wdata;
    assign arb_busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cacheline_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_port_arbiter
// Description : Directed self-checking bench for cacheline_port_arbiter.
//               A hand-driven adaptor answers each memory request after a
//               chosen number of cycles; expected values are written out
//               per step.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cacheline_port_arbiter;

    localparam logic [255:0] L_AA = {32{8'hAA}};
    localparam logic [255:0] L_55 = {32{8'h55}};
    localparam logic [255:0] L_77 = {32{8'h77}};
    localparam logic [255:0] L_BB = {32{8'hBB}};
    localparam logic [255:0] L_CC = {32{8'hCC}};
    localparam logic [255:0] L_11 = {32{8'h11}};
    localparam logic [255:0] L_EE = {32{8'hEE}};
    localparam logic [255:0] L_33 = {32{8'h33}};
    localparam logic [255:0] L_99 = {32{8'h99}};

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  icache_addr;
    logic         icache_read;
    logic [255:0] icache_rdata;
    logic         icache_resp;
    logic [31:0]  dcache_addr;
    logic         dcache_read;
    logic         dcache_write;
    logic [255:0] dcache_wdata;
    logic [255:0] dcache_rdata;
    logic         dcache_resp;
    logic [31:0]  mem_addr;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic         arb_busy;

    int checks   = 0;
    int failures = 0;
    int i_pulses = 0;
    int d_pulses = 0;
    int viol     = 0;

    always #5 clk = ~clk;

    cacheline_port_arbiter #(
        .DCACHE_FIRST (1),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .icache_addr  (icache_addr),
        .icache_read  (icache_read),
        .icache_rdata (icache_rdata),
        .icache_resp  (icache_resp),
        .dcache_addr  (dcache_addr),
        .dcache_read  (dcache_read),
        .dcache_write (dcache_write),
        .dcache_wdata (dcache_wdata),
        .dcache_rdata (dcache_rdata),
        .dcache_resp  (dcache_resp),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .arb_busy     (arb_busy)
    );

    // Pulse counters and invariant monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (icache_resp === 1'b1) i_pulses++;
        if (dcache_resp === 1'b1) d_pulses++;
        if ((mem_read === 1'b1 && mem_write === 1'b1) ||
            (icache_resp === 1'b1 && dcache_resp === 1'b1)) viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_w32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Adaptor model: counts request cycles and answers on the n-th one.
    task automatic run_mem(input int n, input logic [255:0] line,
                           output int rd, output int wr);
        rd = 0;
        wr = 0;
        for (int k = 0; k < n; k++) begin
            if (mem_read === 1'b1) rd++;
            if (mem_write === 1'b1) wr++;
            if (k == n - 1) begin
                mem_resp  = 1'b1;
                mem_rdata = line;
            end
            tick();
        end
        mem_resp = 1'b0;
    endtask

    initial begin
        int rd;
        int wr;
        int ib;
        int db;
        logic [31:0] exp_addr;

        rst          = 1'b1;
        icache_addr  = 32'd0;
        icache_read  = 1'b0;
        dcache_addr  = 32'd0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        dcache_wdata = 256'd0;
        mem_rdata    = 256'd0;
        mem_resp     = 1'b0;

        // ---------------- reset ----------------
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_bit ("rst_mem_read",  mem_read,    1'b0);
        chk_bit ("rst_mem_write", mem_write,   1'b0);
        chk_w32 ("rst_mem_addr",  mem_addr,    32'd0);
        chk_line("rst_mem_wdata", mem_wdata,   256'd0);
        chk_line("rst_irdata",    icache_rdata, 256'd0);
        chk_line("rst_drdata",    dcache_rdata, 256'd0);
        chk_bit ("rst_iresp",     icache_resp, 1'b0);
        chk_bit ("rst_dresp",     dcache_resp, 1'b0);
        chk_bit ("rst_busy",      arb_busy,    1'b0);

        // ---------------- icache read ----------------
        ib = i_pulses;
        db = d_pulses;
        icache_addr = 32'h0000_0064;
        icache_read = 1'b1;
        tick();
        chk_bit("t1_busy",     arb_busy, 1'b1);
        chk_w32("t1_mem_addr", mem_addr, 32'h0000_0060);
        run_mem(4, L_AA, rd, wr);
        chk_w32 ("t1_read_cycles",  rd, 32'd4);
        chk_w32 ("t1_write_cycles", wr, 32'd0);
        chk_bit ("t1_iresp",        icache_resp, 1'b1);
        chk_line("t1_irdata",       icache_rdata, L_AA);
        chk_bit ("t1_mem_read_off", mem_read, 1'b0);
        chk_bit ("t1_dresp",        dcache_resp, 1'b0);
        icache_read = 1'b0;
        tick();
        chk_bit("t1_iresp_end", icache_resp, 1'b0);
        chk_bit("t1_idle",      arb_busy, 1'b0);
        chk_w32("t1_ipulses",   i_pulses - ib, 32'd1);
        chk_w32("t1_dpulses",   d_pulses - db, 32'd0);

        // ---------------- dcache writeback ----------------
        ib = i_pulses;
        db = d_pulses;
        dcache_addr  = 32'h0000_1040;
        dcache_wdata = L_55;
        dcache_write = 1'b1;
        tick();
        chk_bit ("t2_mem_write", mem_write, 1'b1);
        chk_bit ("t2_mem_read",  mem_read,  1'b0);
        chk_line("t2_mem_wdata", mem_wdata, L_55);
        chk_w32 ("t2_mem_addr",  mem_addr,  32'h0000_1040);
        run_mem(3, L_77, rd, wr);
        chk_w32 ("t2_read_cycles",  rd, 32'd0);
        chk_w32 ("t2_write_cycles", wr, 32'd3);
        chk_bit ("t2_dresp",        dcache_resp, 1'b1);
        chk_line("t2_drdata_kept",  dcache_rdata, 256'd0);
        chk_bit ("t2_mem_write_off", mem_write, 1'b0);
        dcache_write = 1'b0;
        tick();
        chk_bit("t2_idle",    arb_busy, 1'b0);
        chk_w32("t2_dpulses", d_pulses - db, 32'd1);
        chk_w32("t2_ipulses", i_pulses - ib, 32'd0);

        // ---------------- simultaneous reads ----------------
        icache_addr = 32'h0000_0200;
        dcache_addr = 32'h0000_3000;
        icache_read = 1'b1;
        dcache_read = 1'b1;
        tick();
        chk_w32("t3_first_addr", mem_addr, 32'h0000_3000);
        chk_bit("t3_first_read", mem_read, 1'b1);
        run_mem(2, L_BB, rd, wr);
        chk_bit ("t3_dresp",  dcache_resp, 1'b1);
        chk_line("t3_drdata", dcache_rdata, L_BB);
        chk_bit ("t3_iresp0", icache_resp, 1'b0);
        dcache_read = 1'b0;
        tick();
        chk_bit("t3_idle_gap", arb_busy, 1'b0);
        tick();
        chk_w32("t3_second_addr", mem_addr, 32'h0000_0200);
        chk_bit("t3_second_read", mem_read, 1'b1);
        run_mem(3, L_CC, rd, wr);
        chk_bit ("t3_iresp",       icache_resp, 1'b1);
        chk_line("t3_irdata",      icache_rdata, L_CC);
        chk_line("t3_drdata_kept", dcache_rdata, L_BB);
        icache_read = 1'b0;
        tick();
        chk_bit("t3_idle", arb_busy, 1'b0);

        // ---------------- sustained contention ----------------
        icache_addr = 32'h0000_0400;
        dcache_addr = 32'h0000_0800;
        icache_read = 1'b1;
        dcache_read = 1'b1;
        for (int g = 0; g < 5; g++) begin
            tick();
            exp_addr = (GUARD && g == 4) ? 32'h0000_0400 : 32'h0000_0800;
            chk_w32($sformatf("t4_grant%0d", g), mem_addr, exp_addr);
            run_mem(1, L_11, rd, wr);
            tick();
        end
        icache_read = 1'b0;
        dcache_read = 1'b0;
        tick();
        chk_bit("t4_idle", arb_busy, 1'b0);

        // ---------------- reset mid-transaction ----------------
        ib = i_pulses;
        db = d_pulses;
        dcache_addr = 32'h0000_5000;
        dcache_read = 1'b1;
        tick();
        chk_bit("t5_mem_read", mem_read, 1'b1);
        tick();
        rst         = 1'b1;
        dcache_read = 1'b0;
        tick();
        chk_bit ("t5_rst_mem_read",  mem_read,  1'b0);
        chk_bit ("t5_rst_mem_write", mem_write, 1'b0);
        chk_bit ("t5_rst_busy",      arb_busy,  1'b0);
        chk_line("t5_rst_drdata",    dcache_rdata, 256'd0);
        chk_line("t5_rst_irdata",    icache_rdata, 256'd0);
        rst       = 1'b0;
        mem_resp  = 1'b1;
        mem_rdata = L_EE;
        tick();
        mem_resp = 1'b0;
        tick();
        chk_bit ("t5_late_busy",   arb_busy, 1'b0);
        chk_line("t5_late_drdata", dcache_rdata, 256'd0);
        chk_w32 ("t5_dpulses",     d_pulses - db, 32'd0);
        chk_w32 ("t5_ipulses",     i_pulses - ib, 32'd0);

        // ---------------- stray mem_resp while idle ----------------
        mem_resp  = 1'b1;
        mem_rdata = L_33;
        tick();
        mem_resp = 1'b0;
        chk_bit ("t6_busy",      arb_busy,  1'b0);
        tick();
        chk_bit ("t6_mem_read",  mem_read,  1'b0);
        chk_bit ("t6_mem_write", mem_write, 1'b0);
        chk_w32 ("t6_mem_addr",  mem_addr,  32'd0);
        chk_line("t6_mem_wdata", mem_wdata, 256'd0);
        chk_line("t6_irdata",    icache_rdata, 256'd0);
        chk_line("t6_drdata",    dcache_rdata, 256'd0);
        chk_bit ("t6_iresp",     icache_resp, 1'b0);
        chk_bit ("t6_dresp",     dcache_resp, 1'b0);

        // ---------------- read+write together acts as write ----------------
        dcache_addr  = 32'h0000_6000;
        dcache_wdata = L_99;
        dcache_read  = 1'b1;
        dcache_write = 1'b1;
        tick();
        chk_bit ("t7_mem_write", mem_write, 1'b1);
        chk_bit ("t7_mem_read",  mem_read,  1'b0);
        chk_line("t7_mem_wdata", mem_wdata, L_99);
        run_mem(1, L_33, rd, wr);
        chk_bit ("t7_dresp",       dcache_resp, 1'b1);
        chk_line("t7_drdata_kept", dcache_rdata, 256'd0);
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        tick();
        chk_bit("t7_idle", arb_busy, 1'b0);

        chk_w32("invariants", viol, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cacheline_port_arbiter.md
Name: cacheline_port_arbiter

Overview:
- Shares the single cacheline adaptor / burst-memory port between the icache and dcache miss/writeback paths.
- Accepts one 256-bit cacheline request at a time from either cache and latches its address and write data.
- Sequences a single read or write on the memory side, then returns the data and a one-cycle response to the owning cache.
- Sits between the icache/dcache pmem_* ports and the cacheline_adaptor line-side port.

Parameters:
- DCACHE_FIRST, 1, priority on a simultaneous request: 1 = dcache wins, 0 = icache wins.
- STARVE_LIMIT, 4, consecutive grants to the winning side before the losing side is forced (used only with ARB_STARVE_GUARD_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- icache_addr  in  32  icache line address
- icache_read  in  1  icache line read request, held until icache_resp
- icache_rdata  out  256  line returned to icache
- icache_resp  out  1  one-cycle completion pulse to icache
- dcache_addr  in  32  dcache line address
- dcache_read  in  1  dcache line read request, held until dcache_resp
- dcache_write  in  1  dcache writeback request, held until dcache_resp
- dcache_wdata  in  256  writeback line
- dcache_rdata  out  256  line returned to dcache
- dcache_resp  out  1  one-cycle completion pulse to dcache
- mem_addr  out  32  line address to adaptor, bits [4:0] forced to 0
- mem_read  out  1  read request to adaptor
- mem_write  out  1  write request to adaptor
- mem_wdata  out  256  write line to adaptor
- mem_rdata  in  256  line from adaptor
- mem_resp  in  1  adaptor completion
- arb_busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset, synchronous active-high on rst: state = IDLE; all outputs 0; latched addr/wdata/rdata registers = 0; starve counter = 0. A reset mid-transaction abandons it; no resp is ever issued for it.
- States: IDLE, MEM_I, MEM_D, RESP_I, RESP_D.
- IDLE: samples requests each cycle.
  - icache only -> MEM_I.
  - dcache only -> MEM_D.
  - Both -> by DCACHE_FIRST (subject to the optional guard).
  - On the transition, latch the winner's addr with [4:0] cleared, the op (read/write) and, for a write, dcache_wdata.
- MEM_I / MEM_D:
  - mem_addr and mem_wdata are driven from the latches.
  - mem_read (or mem_write) is registered, high from the first cycle in the state until the cycle mem_resp is seen.
  - Requester input changes while in these states are ignored.
  - On mem_resp: capture mem_rdata (reads only), drop mem_read/mem_write in the next cycle, go to RESP_I / RESP_D.
- RESP_I / RESP_D: the matching resp is high for exactly one cycle; the matching rdata holds the captured line. The state then returns to IDLE.
- Latency, uncontended read: request seen in IDLE cycle 0 -> mem_read high from cycle 1 -> mem_resp at cycle N -> resp at cycle N+1 -> IDLE at N+2.
- A request held in the cycle after resp is treated as a new request.
- icache_rdata / dcache_rdata hold their last captured value outside resp cycles.
- dcache_read and dcache_write both high is illegal; the arbiter treats it as a write.
- dcache write: dcache_rdata is not updated; dcache_resp still pulses.
- mem_resp outside MEM_* states is ignored.
- Never more than one of mem_read / mem_write is high; never both resps in the same cycle.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A 3-bit counter counts consecutive contended grants to the priority side; it resets to 0 whenever the other side is granted or no contention occurs.
  - When the counter reaches STARVE_LIMIT and both sides request in IDLE, the non-priority side is granted and the counter clears.
- Undefined: strict fixed priority; no counter logic is present.

Test Plan:
- icache_read=1, addr 0x0000_0064, mem_resp 4 cycles after mem_read with line 0xAA..AA -> mem_addr=0x0000_0060, mem_read high 4 cycles, icache_resp one pulse, icache_rdata=0xAA..AA, dcache_resp stays 0.
- dcache_write=1, addr 0x0000_1040, wdata 0x55..55 -> mem_write=1, mem_wdata=0x55..55, mem_read=0 throughout, dcache_resp one pulse, dcache_rdata unchanged.
- icache_read and dcache_read rise in the same cycle with DCACHE_FIRST=1 -> dcache serviced first; icache granted in the IDLE cycle after dcache_resp; icache_resp follows its own mem_resp.
- Both held continuously with ARB_STARVE_GUARD_EN, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,...; without the macro, icache is never granted while dcache_read is held.
- rst asserted in MEM_D with mem_resp pending -> next cycle mem_read=0, mem_write=0, arb_busy=0, no resp pulses; a later mem_resp is ignored.
- mem_resp pulsed while IDLE, no requests -> no state change, no resp, all outputs stay 0.
